// File: rtl/square_wave_oscillator.sv
// rtl/square_wave_oscillator.sv - tick-driven square wave with per-period latched high/low lengths.
// Optional macro SQUARE_OSC_SYNC_RESTART_EN: disable restarts the period instead of pausing it.
module square_wave_oscillator #(
  parameter int                 SAMPLE_RATE = 48000,
  parameter logic signed [15:0] HIGH_LEVEL  = 16'sd16384,
  parameter logic signed [15:0] LOW_LEVEL   = -16'sd16384
) (
  input  logic               clk,
  input  logic               I_RST,
  input  logic               audio_clk_en,
  input  logic               enable,
  input  logic        [15:0] high_ticks,
  input  logic        [15:0] low_ticks,
  output logic signed [15:0] out,
  output logic               period_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  state_e             state_q;
  logic        [15:0] cnt_q;
  logic        [15:0] hi_q;
  logic        [15:0] lo_q;
  logic signed [15:0] out_q;
  logic               period_done_q;
`ifndef SQUARE_OSC_SYNC_RESTART_EN
  logic               pause_q;
`endif

  logic        [15:0] hi_len_d;
  logic        [15:0] lo_len_d;
  logic        [15:0] hi_last_d;
  logic        [15:0] lo_last_d;
  logic               unused_sample_rate;

  assign unused_sample_rate = (SAMPLE_RATE > 0);

  // Clamping at latch time keeps the last-count compare within 0..65534.
  assign hi_len_d  = (high_ticks == 16'd0) ? 16'd1 : high_ticks;
  assign lo_len_d  = (low_ticks == 16'd0) ? 16'd1 : low_ticks;
  assign hi_last_d = hi_q - 16'd1;
  assign lo_last_d = lo_q - 16'd1;

  always_ff @(posedge clk) begin
    if (I_RST) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      out_q         <= '0;
      period_done_q <= 1'b0;
`ifndef SQUARE_OSC_SYNC_RESTART_EN
      pause_q       <= 1'b0;
`endif
    end else begin
      period_done_q <= 1'b0;
      if (audio_clk_en) begin
        if (!enable) begin
          out_q <= '0;
`ifdef SQUARE_OSC_SYNC_RESTART_EN
          state_q <= S_IDLE;
          cnt_q   <= '0;
`else
          if (state_q != S_IDLE) pause_q <= 1'b1;
`endif
        end else begin
`ifndef SQUARE_OSC_SYNC_RESTART_EN
          // A resume tick is also an ordinary phase tick at the frozen count.
          if (pause_q) pause_q <= 1'b0;
`endif
          case (state_q)
            S_IDLE: begin
              hi_q    <= hi_len_d;
              lo_q    <= lo_len_d;
              cnt_q   <= '0;
              state_q <= S_HIGH;
              out_q   <= HIGH_LEVEL;
            end
            S_HIGH: begin
              if (cnt_q == hi_last_d) begin
                cnt_q   <= '0;
                state_q <= S_LOW;
                out_q   <= LOW_LEVEL;
              end else begin
                cnt_q <= cnt_q + 16'd1;
                out_q <= HIGH_LEVEL;
              end
            end
            S_LOW: begin
              if (cnt_q == lo_last_d) begin
                cnt_q         <= '0;
                hi_q          <= hi_len_d;
                lo_q          <= lo_len_d;
                state_q       <= S_HIGH;
                out_q         <= HIGH_LEVEL;
                period_done_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 16'd1;
                out_q <= LOW_LEVEL;
              end
            end
            default: begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              out_q   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign out         = out_q;
  assign period_done = period_done_q;

endmodule

// File: tb/tb_square_wave_oscillator.sv
// tb/tb_square_wave_oscillator.sv - directed bench with a sample-queue model of the oscillator.
module tb_square_wave_oscillator;

  localparam int H = 16384;
  localparam int L = -16384;

  logic               clk = 1'b0;
  logic               I_RST;
  logic               audio_clk_en;
  logic               enable;
  logic        [15:0] high_ticks;
  logic        [15:0] low_ticks;
  logic signed [15:0] out;
  logic               period_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  square_wave_oscillator dut (
    .clk         (clk),
    .I_RST       (I_RST),
    .audio_clk_en(audio_clk_en),
    .enable      (enable),
    .high_ticks  (high_ticks),
    .low_ticks   (low_ticks),
    .out         (out),
    .period_done (period_done)
  );

  // Model: one queued sample per enabled tick; a period is its high samples then its low samples.
  typedef struct {
    logic signed [15:0] lvl;
    bit                 pd;
  } samp_t;

  samp_t              q[$];
  bit                 m_run = 1'b0;
  logic signed [15:0] exp_out = '0;
  bit                 exp_pd = 1'b0;
  bit                 chk_on = 1'b0;

  int ol[$];
  int pl[$];
  int eo[$];
  int ep[$];

  function automatic int eff(input logic [15:0] n);
    return (n == 16'd0) ? 1 : int'(n);
  endfunction

  function automatic void fill(input logic [15:0] h, input logic [15:0] l, input bit first_pd);
    int nh;
    int nl;
    nh = eff(h);
    nl = eff(l);
    for (int i = 0; i < nh; i++) q.push_back(samp_t'{16'sd16384, (i == 0) && first_pd});
    for (int i = 0; i < nl; i++) q.push_back(samp_t'{-16'sd16384, 1'b0});
  endfunction

  always @(posedge clk) begin
    samp_t s;
    if (I_RST) begin
      q.delete();
      m_run   = 1'b0;
      exp_out = '0;
      exp_pd  = 1'b0;
    end else begin
      exp_pd = 1'b0;
      if (audio_clk_en) begin
        if (!enable) begin
          exp_out = '0;
`ifdef SQUARE_OSC_SYNC_RESTART_EN
          m_run = 1'b0;
          q.delete();
`endif
        end else begin
          if (!m_run) begin
            q.delete();
            fill(high_ticks, low_ticks, 1'b0);
            m_run = 1'b1;
          end else if (q.size() == 0) begin
            fill(high_ticks, low_ticks, 1'b1);
          end
          s       = q.pop_front();
          exp_out = s.lvl;
          exp_pd  = s.pd;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (out !== exp_out || period_done !== exp_pd) begin
        bad++;
        $display("FAIL cycle t=%0t: out=%0d period_done=%b, expected out=%0d period_done=%b",
                 $time, out, period_done, exp_out, exp_pd);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_seq(input string name);
    check($sformatf("%s_len", name), ol.size(), eo.size());
    for (int i = 0; i < eo.size() && i < ol.size(); i++) begin
      check($sformatf("%s_out%0d", name, i), ol[i], eo[i]);
      check($sformatf("%s_pd%0d", name, i), pl[i], ep[i]);
    end
  endtask

  task automatic tick(input bit en, input int gap);
    audio_clk_en = 1'b1;
    enable       = en;
    @(negedge clk);
    ol.push_back(int'(exp_out));
    pl.push_back(int'(exp_pd));
    audio_clk_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    I_RST        = 1'b1;
    audio_clk_en = 1'b1;
    enable       = 1'b1;
    repeat (2) @(negedge clk);
    I_RST        = 1'b0;
    audio_clk_en = 1'b0;
    ol.delete();
    pl.delete();
  endtask

  initial begin
    int n;
    I_RST        = 1'b1;
    audio_clk_en = 1'b0;
    enable       = 1'b0;
    high_ticks   = 16'd3;
    low_ticks    = 16'd2;

    do_reset();
    chk_on = 1'b1;
    check("reset_out", out, 0);
    check("reset_pd", period_done, 0);

    // 3/2 period, ticks every 4th clk
    repeat (10) tick(1'b1, 3);
    eo = {H, H, H, L, L, H, H, H, L, L};
    ep = {0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    check_seq("p32");

    // high_ticks changes mid-period; only the next period sees it
    ol.delete(); pl.delete();
    tick(1'b1, 1);
    high_ticks = 16'd5;
    repeat (10) tick(1'b1, 1);
    eo = {H, H, H, L, L, H, H, H, H, H, L};
    ep = {1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    check_seq("reload");

    // zero lengths behave as one tick each
    high_ticks = 16'd0;
    low_ticks  = 16'd0;
    do_reset();
    repeat (6) tick(1'b1, 0);
    eo = {H, L, H, L, H, L};
    ep = {0, 0, 1, 0, 1, 0};
    check_seq("zero");

    // disable on the 2nd high tick, re-enable 4 ticks later
    high_ticks = 16'd3;
    low_ticks  = 16'd2;
    do_reset();
    tick(1'b1, 1);
    repeat (4) tick(1'b0, 1);
    repeat (6) tick(1'b1, 1);
`ifdef SQUARE_OSC_SYNC_RESTART_EN
    eo = {H, 0, 0, 0, 0, H, H, H, L, L, H};
    ep = {0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
`else
    eo = {H, 0, 0, 0, 0, H, H, L, L, H, H};
    ep = {0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
`endif
    check_seq("pause");

    // reset with a tick on the same edge, at the end of the low phase
    do_reset();
    repeat (5) tick(1'b1, 0);
    I_RST        = 1'b1;
    audio_clk_en = 1'b1;
    enable       = 1'b1;
    @(negedge clk);
    check("rst_mid_out", out, 0);
    check("rst_mid_pd", period_done, 0);
    I_RST        = 1'b0;
    audio_clk_en = 1'b0;
    @(negedge clk);
    ol.delete(); pl.delete();
    repeat (2) tick(1'b1, 0);
    eo = {H, H};
    ep = {0, 0};
    check_seq("restart");

    // maximum high length, no wrap
    high_ticks = 16'hFFFF;
    low_ticks  = 16'd1;
    do_reset();
    repeat (65537) tick(1'b1, 0);
    n = 0;
    while (n < ol.size() && ol[n] == H) n++;
    check("long_high_len", n, 65535);
    check("long_low", ol[65535], L);
    check("long_wrap_out", ol[65536], H);
    check("long_wrap_pd", pl[65536], 1);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
